psum_row_accumulator: RTL and testbench
=======================================

# psum_row_accumulator

Consumer of the per-row partial sums that the 1-D conv row engine produces. Each engine result is a 4-lane row of 32-bit partial sums for one kernel row. This block accumulates `KROWS` consecutive rows lane by lane into one finished output row of the 2-D convolution. It presents that row on a valid/ready output interface and applies backpressure to the engine side when the output is blocked.

## Interface
Parameters:
- `LANES`, 4 — output pixels per row; one accumulator per lane.
- `PSUM_W`, 32 — width of each signed partial-sum lane in and out.
- `KROWS`, 7 — kernel rows summed per output row; must be ≥2.
- `RELU`, 0 — when 1, negative finished sums are output as 0.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — `psum` holds a valid row (the engine's enable delayed one cycle).
- `in_ready`  out  1  — row accepted when `in_valid` and `in_ready` are both high.
- `psum`  in  `LANES*PSUM_W`  — lane k at bits `[(k+1)*PSUM_W-1 : k*PSUM_W]`, signed.
- `flush`  in  1  — abandons the current window.
- `row_idx`  out  `clog2(KROWS)`  — index of the next kernel row expected.
- `out_valid`  out  1  — finished row available.
- `out_ready`  in  1  — downstream accepts when `out_valid` and `out_ready` are both high.
- `out_data`  out  `LANES*PSUM_W`  — finished row, same lane packing as `psum`.

## Operation
- **State:** lane accumulators `acc[k]` (`PSUM_W` bits, signed), row counter `row_idx` (0..`KROWS`-1), and an output register with `out_valid`.
- **Accept on a non-final row** (`row_idx` < `KROWS`-1):
  - `acc[k]` ← (`row_idx`==0 ? 0 : `acc[k]`) + `psum[k]`.
  - `row_idx` increments.
- **Accept on the final row** (`row_idx`==`KROWS`-1):
  - Output register ← `acc[k]` + `psum[k]`, passed through ReLU if `RELU`=1.
  - `out_valid` ← 1.
  - `row_idx` ← 0.
  - `acc` is don't-care; the next row-0 accept overwrites it.
- **Arithmetic:** two's-complement addition modulo 2^`PSUM_W`. No saturation and no overflow flag.
- **Backpressure:** `in_ready` = !`flush` && !(`row_idx`==`KROWS`-1 && `out_valid` && !`out_ready`).
  - Rows 0..`KROWS`-2 of the next window are always accepted while the output is held, so the next window can start filling.
- **Output release:** an output handshake with no final-row accept in the same cycle clears `out_valid`. `out_data` then holds its last value.
- **Simultaneous output handshake and final-row accept:** the new row is loaded and `out_valid` stays 1. There is no bubble.
- **`flush`:**
  - `row_idx` ← 0 and `acc` ← 0.
  - `in_ready` is 0 that cycle, so no row is accepted.
  - The output register and `out_valid` are untouched; a pending result is still delivered.
- **`rst`:** overrides everything, including mid-window or mid-handshake.
  - Reset values: `acc`=0, `row_idx`=0, `out_valid`=0, `out_data`=0.
  - `in_ready` is 1 in the first cycle after reset.
- **Priority:** `rst` > `flush` > input accept. Output handshake is evaluated independently of these.

## Timing
- `in_ready` and `out_valid` are combinational from registered state and `out_ready`/`flush`; neither depends on `in_valid`.
- Latency: final-row accept at edge t gives `out_valid`=1 and valid `out_data` from t until the handshake edge.
- Throughput: one row per cycle sustained. One finished row every `KROWS` accepted rows while `out_ready`=1.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Back-to-back windows with `out_ready` held at 1 produce no stall.

## Test plan
- **Basic sum:** reset, then 7 consecutive rows with every lane = 1 and `out_ready`=1.
  - `out_valid` pulses one cycle after the 7th accept.
  - All lanes of `out_data` = 7; `row_idx` returns to 0.
- **Signed sum and ReLU:** 7 rows with lane0 = -5 and lane3 = 0x00000010.
  - `RELU`=0: lane0 = 0xFFFFFFDD, lane3 = 0x00000070.
  - `RELU`=1: lane0 = 0, lane3 = 0x00000070.
- **Wrap-around:** row 0 lane1 = 0x7FFFFFFF, row 1 lane1 = 1, remaining rows 0.
  - Lane1 output = 0x80000000.
- **Backpressure:**
  - Window A completes with `out_ready`=0. Rows 0–5 of window B are still accepted.
  - `in_ready`=0 at `row_idx`=6 until `out_ready` rises.
  - In the handshake cycle, B's final row loads with no bubble. A's data is seen first, then B's.
- **Flush:** flush after 3 rows of a window, then feed 7 rows of value 2.
  - Output = 14, with none of the pre-flush rows included.
  - A flush while `out_valid`=1 leaves that result intact.
- **Reset mid-operation:** assert `rst` with `row_idx`=4 and `out_valid`=1.
  - Next cycle: `out_valid`=0, `out_data`=0, `row_idx`=0, `in_ready`=1.

Source files
------------

// File: rtl/psum_row_accumulator.sv
// Accumulates KROWS consecutive per-kernel-row partial-sum rows lane by lane into
// one finished conv output row, presented on a valid/ready port with input backpressure.
module psum_lane #(
    parameter int PSUM_W = 32,
    parameter int RELU   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              first,
    input  logic              fin,
    input  logic [PSUM_W-1:0] din,
    output logic [PSUM_W-1:0] dout
);
    logic [PSUM_W-1:0] acc;
    logic [PSUM_W-1:0] sum;

    // Row 0 starts a fresh window, so the stale accumulator is ignored rather than cleared.
    assign sum = (first ? '0 : acc) + din;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            dout <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (load)
                acc <= sum;
            if (fin)
                dout <= ((RELU != 0) && sum[PSUM_W-1]) ? '0 : sum;
        end
    end
endmodule

module psum_row_accumulator #(
    parameter int LANES  = 4,
    parameter int PSUM_W = 32,
    parameter int KROWS  = 7,
    parameter int RELU   = 0,
    localparam int RW    = (KROWS > 1) ? $clog2(KROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*PSUM_W-1:0] psum,
    input  logic                    flush,
    output logic [RW-1:0]           row_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*PSUM_W-1:0] out_data
);
    localparam logic [RW-1:0] LAST = RW'(KROWS - 1);

    logic [LANES-1:0][PSUM_W-1:0] psum_l;
    logic [LANES-1:0][PSUM_W-1:0] out_l;
    logic last;
    logic accept;
    logic load;
    logic fin;

    assign psum_l   = psum;
    assign out_data = out_l;
    assign last     = (row_idx == LAST);
    // Only the final row needs the output slot; earlier rows of the next window keep flowing.
    assign in_ready = !flush && !(last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && !last;
    assign fin      = accept && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (flush)
                row_idx <= '0;
            else if (accept)
                row_idx <= last ? '0 : row_idx + RW'(1);
            if (fin)
                out_valid <= 1'b1;
            else if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        psum_lane #(.PSUM_W(PSUM_W), .RELU(RELU)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (flush),
            .load (load),
            .first(row_idx == '0),
            .fin  (fin),
            .din  (psum_l[k]),
            .dout (out_l[k])
        );
    end
endmodule

// File: tb/tb_psum_row_accumulator.sv
// Directed bench for psum_row_accumulator: a window-level model (accepted rows grouped
// per window, summed, queued) checked every cycle, plus literal expectations per scenario.
module tb_psum_row_accumulator;
    localparam int LANES  = 4;
    localparam int PSUM_W = 32;
    localparam int KROWS  = 7;
    localparam int RW     = $clog2(KROWS);
    localparam int DW     = LANES * PSUM_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] psum = '0;
    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic [RW-1:0] row_idx0, row_idx1;
    logic [DW-1:0] out_data0, out_data1;

    always #5 clk = ~clk;

    psum_row_accumulator #(.LANES(LANES), .PSUM_W(PSUM_W), .KROWS(KROWS), .RELU(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .psum(psum),
        .flush(flush), .row_idx(row_idx0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0));

    psum_row_accumulator #(.LANES(LANES), .PSUM_W(PSUM_W), .KROWS(KROWS), .RELU(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .psum(psum),
        .flush(flush), .row_idx(row_idx1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pk(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Model: partial window sums over accepted rows; finished rows queue until handshaken.
    logic [PSUM_W-1:0] part [LANES];
    logic [DW-1:0]     q0[$], q1[$];
    logic [DW-1:0]     done0 = '0, done1 = '0;
    int                n_done = 0;
    int                cnt = 0;

    always @(negedge clk) begin
        logic          exp_rdy;
        logic [DW-1:0] r0, r1;
        if (rst) begin
            q0.delete(); q1.delete();
            cnt = 0;
            for (int k = 0; k < LANES; k++) part[k] = '0;
        end else begin
            exp_rdy = !flush && !(cnt == KROWS-1 && q0.size() != 0 && !out_ready);
            chk("row_idx", DW'(row_idx0), DW'(cnt));
            chk("row_idx_relu", DW'(row_idx1), DW'(cnt));
            chk("in_ready", DW'(in_ready0), DW'(exp_rdy));
            chk("in_ready_relu", DW'(in_ready1), DW'(exp_rdy));
            chk("out_valid", DW'(out_valid0), DW'(q0.size() != 0));
            chk("out_valid_relu", DW'(out_valid1), DW'(q1.size() != 0));
            if (q0.size() != 0) begin
                chk("out_data", out_data0, q0[0]);
                chk("out_data_relu", out_data1, q1[0]);
                if (out_ready) begin
                    done0 = q0.pop_front();
                    done1 = q1.pop_front();
                    n_done++;
                end
            end
            if (flush) begin
                cnt = 0;
                for (int k = 0; k < LANES; k++) part[k] = '0;
            end else if (in_valid && exp_rdy) begin
                for (int k = 0; k < LANES; k++) part[k] = part[k] + psum[k*PSUM_W +: PSUM_W];
                cnt++;
                if (cnt == KROWS) begin
                    for (int k = 0; k < LANES; k++) begin
                        r0[k*PSUM_W +: PSUM_W] = part[k];
                        r1[k*PSUM_W +: PSUM_W] = part[k][PSUM_W-1] ? '0 : part[k];
                        part[k] = '0;
                    end
                    q0.push_back(r0);
                    q1.push_back(r1);
                    cnt = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds a row on the input until the edge at which in_ready is high.
    task automatic send(input logic [DW-1:0] v);
        logic ok;
        int   n;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        psum = v;
        while (!ok && n < 60) begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: got stalled want accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [DW-1:0] v);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic wait_done(input int prev, input string name, input logic [DW-1:0] e0,
                             input logic [DW-1:0] e1);
        int n;
        n = 0;
        while (n_done == prev && n < 40) begin cyc(); n++; end
        if (n_done == prev) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no output want handshake", name);
        end else begin
            chk(name, done0, e0);
            chk({name, "_relu"}, done1, e1);
        end
    endtask

    initial begin
        int prev;
        logic [DW-1:0] ones, threes, sevens;
        ones   = pk(1, 1, 1, 1);
        threes = pk(3, 3, 3, 3);
        sevens = pk(7, 7, 7, 7);

        repeat (2) cyc();
        chk("reset_out_valid", DW'(out_valid0), '0);
        chk("reset_out_data", out_data0, '0);
        chk("reset_row_idx", DW'(row_idx0), '0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", DW'(in_ready0), DW'(1));

        // Basic sum
        out_ready = 1'b1;
        prev = n_done;
        send_n(KROWS, ones);
        chk("basic_valid", DW'(out_valid0), DW'(1));
        chk("basic_data", out_data0, sevens);
        chk("basic_row_idx", DW'(row_idx0), '0);
        cyc();
        chk("basic_release", DW'(out_valid0), '0);
        wait_done(prev, "basic_done", sevens, sevens);

        // Signed sum and ReLU
        prev = n_done;
        send_n(KROWS, pk(32'hFFFFFFFB, 0, 0, 32'h10));
        wait_done(prev, "signed", pk(32'hFFFFFFDD, 0, 0, 32'h70), pk(0, 0, 0, 32'h70));

        // Wrap-around
        prev = n_done;
        send(pk(0, 32'h7FFFFFFF, 0, 0));
        send(pk(0, 1, 0, 0));
        send_n(KROWS-2, '0);
        wait_done(prev, "wrap", pk(0, 32'h80000000, 0, 0), '0);

        // Backpressure: A held, B rows 0..5 flow, B's final row lands on A's handshake
        out_ready = 1'b0;
        prev = n_done;
        send_n(KROWS, ones);
        send_n(KROWS-1, threes);
        chk("bp_row_idx", DW'(row_idx0), DW'(KROWS-1));
        chk("bp_in_ready", DW'(in_ready0), '0);
        chk("bp_hold_data", out_data0, sevens);
        fork
            send(threes);
            begin
                repeat (3) @(posedge clk);
                #3 out_ready = 1'b1;
            end
        join
        chk("bp_first_out", done0, sevens);
        chk("bp_no_bubble_valid", DW'(out_valid0), DW'(1));
        chk("bp_no_bubble_data", out_data0, pk(21, 21, 21, 21));
        wait_done(prev + 1, "bp_second_out", pk(21, 21, 21, 21), pk(21, 21, 21, 21));

        // Flush drops the partial window
        prev = n_done;
        send_n(3, pk(5, 5, 5, 5));
        flush = 1'b1;
        #1;
        chk("flush_in_ready", DW'(in_ready0), '0);
        cyc();
        flush = 1'b0;
        send_n(KROWS, pk(2, 2, 2, 2));
        wait_done(prev, "flush_sum", pk(14, 14, 14, 14), pk(14, 14, 14, 14));

        // Flush while a result is pending leaves it intact
        out_ready = 1'b0;
        send_n(KROWS, ones);
        send_n(2, pk(9, 9, 9, 9));
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_keep_valid", DW'(out_valid0), DW'(1));
        chk("flush_keep_data", out_data0, sevens);
        chk("flush_row_idx", DW'(row_idx0), '0);
        prev = n_done;
        out_ready = 1'b1;
        wait_done(prev, "flush_pending", sevens, sevens);
        prev = n_done;
        send_n(KROWS, ones);
        wait_done(prev, "post_flush", sevens, sevens);

        // Reset mid-operation
        out_ready = 1'b0;
        send_n(KROWS, ones);
        send_n(4, ones);
        chk("pre_rst_row_idx", DW'(row_idx0), DW'(4));
        chk("pre_rst_valid", DW'(out_valid0), DW'(1));
        rst = 1'b1;
        cyc();
        chk("rst_out_valid", DW'(out_valid0), '0);
        chk("rst_out_data", out_data0, '0);
        chk("rst_row_idx", DW'(row_idx0), '0);
        chk("rst_in_ready", DW'(in_ready0), DW'(1));
        rst = 1'b0;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
